t5_fetch: RTL

- Instruction fetch stage. Sits directly upstream of the decode stage.
- Masters the Wishbone classic instruction bus, maintains the fetch PC, and accepts branch/jump redirects from execute.
- Holds one fetched instruction in an output register. fins drives the decode stage's instruction input; fpc drives its PC input.
- Enable handshake: fvld qualifies the output register; decode consumes the held instruction on any cycle where sena=1 and fvld=1.

---
 rtl/t5_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/t5_fetch.sv
// Instruction fetch stage: Wishbone classic instruction master, fetch PC,
// redirect handling and a single-entry output register feeding decode.
module t5_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sena,
  input  logic        xbra,
  input  logic [31:0] xtgt,
  output logic [31:0] iwb_adr,
  output logic        iwb_cyc,
  output logic        iwb_stb,
  output logic [3:0]  iwb_sel,
  output logic        iwb_we,
  input  logic [31:0] iwb_dat,
  input  logic        iwb_ack,
  input  logic        iwb_err,
  output logic [31:0] fpc,
  output logic [31:0] fins,
  output logic        fvld,
  output logic        ferr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        kill_q, kill_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] fins_q, fins_d;
  logic        fvld_q, fvld_d;
  logic        ferr_q, ferr_d;

  logic        term;
  logic        free;
  logic        load;
  logic [31:0] xtgt_al;

  assign term    = iwb_ack | iwb_err;
  assign free    = ~fvld_q | sena;
  assign xtgt_al = {xtgt[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    tgt_d   = tgt_q;
    kill_d  = kill_q;
    fpc_d   = fpc_q;
    fins_d  = fins_q;
    fvld_d  = fvld_q;
    ferr_d  = ferr_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (xbra) begin
          adr_d   = xtgt_al;
          state_d = BUSY;
        end else if (free) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xbra) begin
          // An open cycle must finish, so a redirect without term is parked.
          if (term) begin
            adr_d  = xtgt_al;
            kill_d = 1'b0;
          end else begin
            kill_d = 1'b1;
            tgt_d  = xtgt_al;
          end
        end else if (term) begin
          if (kill_q) begin
            kill_d = 1'b0;
            adr_d  = tgt_q;
          end else if (free) begin
            load  = 1'b1;
            adr_d = adr_q + 32'd4;
          end else begin
            // No room for the data: drop it and refetch the same address later.
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fins_d = iwb_err ? 32'h0 : iwb_dat;
      fpc_d  = adr_q;
      ferr_d = iwb_err;
      fvld_d = 1'b1;
    end else if (xbra || (sena && fvld_q)) begin
      fins_d = NOP_INS;
      ferr_d = 1'b0;
      fvld_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= IDLE;
      adr_q   <= PC0;
      tgt_q   <= PC0;
      kill_q  <= 1'b0;
      fpc_q   <= PC0;
      fins_q  <= NOP_INS;
      fvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      fpc_q   <= fpc_d;
      fins_q  <= fins_d;
      fvld_q  <= fvld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign iwb_adr = adr_q;
  assign iwb_cyc = (state_q == BUSY);
  assign iwb_stb = iwb_cyc;
  assign iwb_sel = 4'hF;
  assign iwb_we  = 1'b0;
  assign fpc     = fpc_q;
  assign fins    = fins_q;
  assign fvld    = fvld_q;
  assign ferr    = ferr_q;

endmodule
